// File: rtl/alarm_pkg.sv
// Shared types and sizing helpers for the alarm annunciator.
// Optional feature macro used by the top: ALARM_LATCH_EN.
package alarm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMING,
        BEEP_ON,
        BEEP_OFF,
        MUTED
    } state_e;

    localparam int BEEP_CNT_W = 8;

    function automatic int cnt_width(
        input int a,
        input int b,
        input int c,
        input int d
    );
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/alarm_sync.sv
// Two-flop synchroniser for the asynchronous alarm request.
// Resets to 0 asynchronously (active-low).
module alarm_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/alarm_annunciator.sv
// Debounced alarm annunciator: buzzer cadence, lamp, ack/mute re-arm.
// Define ALARM_LATCH_EN to latch an accepted alarm until acknowledged.
module alarm_annunciator
    import alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = 16,
    parameter int BEEP_ON_CYC    = 8,
    parameter int BEEP_OFF_CYC   = 8,
    parameter int ESCALATE_BEEPS = 4,
    parameter int MUTE_CYC       = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alarm_req,
    input  logic                  ack,
    output logic                  buzzer,
    output logic                  lamp,
    output logic                  active,
    output logic                  escalated,
    output logic [BEEP_CNT_W-1:0] beep_cnt
);

    localparam int CW = cnt_width(DEBOUNCE_CYC, BEEP_ON_CYC,
                                  BEEP_OFF_CYC, MUTE_CYC);
    localparam int OFF_FAST_I = (BEEP_OFF_CYC / 2 < 1) ?
                                1 : BEEP_OFF_CYC / 2;

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] DEB_L    = CW'(DEBOUNCE_CYC);
    localparam logic [CW-1:0] ON_L     = CW'(BEEP_ON_CYC);
    localparam logic [CW-1:0] OFF_L    = CW'(BEEP_OFF_CYC);
    localparam logic [CW-1:0] OFF_F    = CW'(OFF_FAST_I);
    localparam logic [CW-1:0] MUTE_L   = CW'(MUTE_CYC);
    localparam logic [BEEP_CNT_W-1:0] ESC_L = BEEP_CNT_W'(ESCALATE_BEEPS);
    localparam logic [BEEP_CNT_W-1:0] B_ONE = BEEP_CNT_W'(1);

`ifdef ALARM_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic req_s;

    alarm_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (alarm_req),
        .q     (req_s)
    );

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BEEP_CNT_W-1:0] beep_cnt_q, beep_cnt_d;
    logic [CW-1:0]         off_lim;
    logic [BEEP_CNT_W-1:0] beep_inc;
    logic                  leave;

    assign escalated = (beep_cnt_q >= ESC_L);
    assign off_lim   = escalated ? OFF_F : OFF_L;
    assign beep_inc  = (beep_cnt_q == '1) ? beep_cnt_q : beep_cnt_q + B_ONE;

    // Non-latching: a dropped request always clears. Latching: only ack does.
    assign leave = !req_s && (!LATCH || ack);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beep_cnt_d = beep_cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d      = '0;
                beep_cnt_d = '0;
                if (req_s) begin
                    state_d = ARMING;
                    cnt_d   = ONE;
                end
            end
            ARMING: begin
                if (!req_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_L) begin
                    state_d    = BEEP_ON;
                    cnt_d      = ONE;
                    beep_cnt_d = beep_inc;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            BEEP_ON: begin
                if (leave) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    beep_cnt_d = '0;
                end else if (ack) begin
                    state_d = MUTED;
                    cnt_d   = ONE;
                end else if (cnt_q == ON_L) begin
                    state_d = BEEP_OFF;
                    cnt_d   = ONE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            BEEP_OFF: begin
                if (leave) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    beep_cnt_d = '0;
                end else if (ack) begin
                    state_d = MUTED;
                    cnt_d   = ONE;
                end else if (cnt_q >= off_lim) begin
                    state_d    = BEEP_ON;
                    cnt_d      = ONE;
                    beep_cnt_d = beep_inc;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            MUTED: begin
                if (leave) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    beep_cnt_d = '0;
                end else if (ack) begin
                    cnt_d = ONE;
                end else if (cnt_q == MUTE_L) begin
                    if (req_s) begin
                        // Re-arm restarts the escalation sequence.
                        state_d    = BEEP_ON;
                        cnt_d      = ONE;
                        beep_cnt_d = B_ONE;
                    end else begin
                        state_d    = IDLE;
                        cnt_d      = '0;
                        beep_cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d    = IDLE;
                cnt_d      = '0;
                beep_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            beep_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beep_cnt_q <= beep_cnt_d;
        end
    end

    assign buzzer   = (state_q == BEEP_ON);
    assign active   = (state_q == BEEP_ON) || (state_q == BEEP_OFF) ||
                      (state_q == MUTED);
    assign lamp     = active;
    assign beep_cnt = beep_cnt_q;

endmodule

// File: tb/tb_alarm_annunciator.sv
// Directed scoreboard bench for alarm_annunciator (small parameters).
// Latching checks are selected by ALARM_LATCH_EN.
module tb_alarm_annunciator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       alarm_req = 1'b0;
    logic       ack = 1'b0;
    logic       buzzer;
    logic       lamp;
    logic       active;
    logic       escalated;
    logic [7:0] beep_cnt;

    alarm_annunciator #(
        .DEBOUNCE_CYC   (4),
        .BEEP_ON_CYC    (3),
        .BEEP_OFF_CYC   (4),
        .ESCALATE_BEEPS (2),
        .MUTE_CYC       (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alarm_req (alarm_req),
        .ack       (ack),
        .buzzer    (buzzer),
        .lamp      (lamp),
        .active    (active),
        .escalated (escalated),
        .beep_cnt  (beep_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [11:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic push(input string tag, input logic bz,
                        input logic lp, input logic ac,
                        input logic es, input logic [7:0] bc);
        exp_t e;
        e.tag = tag;
        e.v   = {bz, lp, ac, es, bc};
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [11:0] obs;
        obs = {buzzer, lamp, active, escalated, beep_cnt};
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL sb_empty obs=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                failures++;
                $error("FAIL %s bz/lp/ac/es/cnt obs=%b/%b/%b/%b/%0d exp=%b/%b/%b/%b/%0d",
                       e.tag, obs[11], obs[10], obs[9], obs[8], obs[7:0],
                       e.v[11], e.v[10], e.v[9], e.v[8], e.v[7:0]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic bz,
                        input logic lp, input logic ac,
                        input logic es, input logic [7:0] bc);
        push(tag, bz, lp, ac, es, bc);
        tick();
        check_out();
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic on(input string tag, input logic [7:0] c);
        step(tag, 1'b1, 1'b1, 1'b1, c >= 8'd2, c);
    endtask

    task automatic off(input string tag, input logic [7:0] c);
        step(tag, 1'b0, 1'b1, 1'b1, c >= 8'd2, c);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) tick();
        push("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        check_out();
        rst_n = 1'b1;
        idle("post_reset");

        alarm_req = 1'b1;
        for (int e = 0; e < 6; e++)
            idle($sformatf("acc_wait%0d", e));

        for (int k = 1; k <= 2; k++) begin
            for (int i = 0; i < 3; i++)
                on($sformatf("on_b%0d_%0d", k, i), 8'(k));
            for (int i = 0; i < ((k >= 2) ? 2 : 4); i++)
                off($sformatf("off_b%0d_%0d", k, i), 8'(k));
        end
        for (int i = 0; i < 3; i++)
            on($sformatf("on_b3_%0d", i), 8'd3);
        off("off_b3_0", 8'd3);

        ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            off($sformatf("mute%0d", i), 8'd3);
            ack = 1'b0;
        end
        on("rearm", 8'd1);

        alarm_req = 1'b0;
`ifndef ALARM_LATCH_EN
        on("drop_e1", 8'd1);
        on("drop_e2", 8'd1);
        idle("drop_e3");
        idle("drop_e4");
`else
        on("latch_e1", 8'd1);
        on("latch_e2", 8'd1);
        for (int i = 0; i < 4; i++)
            off($sformatf("latch_off%0d", i), 8'd1);
        on("latch_on2", 8'd2);
        ack = 1'b1;
        idle("latch_ack");
        ack = 1'b0;
        idle("latch_idle");
`endif

        alarm_req = 1'b1;
        for (int i = 0; i < 3; i++)
            idle($sformatf("glitch_hi%0d", i));
        alarm_req = 1'b0;
        for (int i = 0; i < 8; i++)
            idle($sformatf("glitch_lo%0d", i));

        alarm_req = 1'b1;
        for (int e = 0; e < 6; e++) begin
            ack = (e == 3);
            idle($sformatf("reacc_wait%0d", e));
        end
        ack = 1'b0;
        on("reacc_on0", 8'd1);
        on("reacc_on1", 8'd1);

        #2 rst_n = 1'b0;
        #1;
        push("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        check_out();
        idle("reset_held");
        rst_n = 1'b1;
        alarm_req = 1'b0;
        idle("after_reset0");
        idle("after_reset1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
